// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter in front of a shared
// WIDTH-bit 2:1 multiplexor. The arbiter owns the mux select and grants
// the path to one requester at a time. Under contention a hold limit
// stops one owner from keeping the path for more than MAX_HOLD cycles.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req0/req1  level requests, held for the whole transfer
//   data0/1    requester data
//   gnt0/gnt1  registered grants (mutually exclusive)
//   sel        registered mux select (0 = data0, 1 = data1)
//   data_out   combinational mux output driven by sel
//   valid_out  gnt0 | gnt1
//   busy       high whenever a requester owns the path
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | no owner; sel holds the last value it had
// OWN0  | requester 0 owns the path (gnt0, sel=0)
// OWN1  | requester 1 owns the path (gnt1, sel=1)

module mux_arbiter #(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // Value of hold_cnt in the owner's last permitted cycle under contention.
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  logic       last, last_nxt;
  logic [7:0] hold_cnt, hold_nxt;
  logic       sel_q, sel_nxt;
  logic       gnt0_q, gnt1_q;
  logic       hold_expired;
  logic [7:0] hold_inc;

  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign hold_inc     = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    hold_nxt  = hold_cnt;
    sel_nxt   = sel_q;

    case (state)
      IDLE: begin
        // On a tie the side that was not served last wins.
        if (req0 && (!req1 || last)) state_nxt = OWN0;
        else if (req1)               state_nxt = OWN1;
      end
      OWN0: begin
        if (!req0)                      state_nxt = req1 ? OWN1 : IDLE;
        else if (req1 && hold_expired)  state_nxt = OWN1;
        else                            hold_nxt  = hold_inc;
      end
      OWN1: begin
        if (!req1)                      state_nxt = req0 ? OWN0 : IDLE;
        else if (req0 && hold_expired)  state_nxt = OWN0;
        else                            hold_nxt  = hold_inc;
      end
      default: state_nxt = IDLE;
    endcase

    // Any state change is an entry: restart the hold count, and on entry
    // to an owner state move sel and remember who was served.
    if (state_nxt != state) begin
      hold_nxt = 8'd0;
      if (state_nxt == OWN0) begin
        last_nxt = 1'b0;
        sel_nxt  = 1'b0;
      end else if (state_nxt == OWN1) begin
        last_nxt = 1'b1;
        sel_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold_cnt <= 8'd0;
      sel_q    <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
      sel_q    <= sel_nxt;
      // Grants get their own flops so a two-bit state change cannot glitch them.
      gnt0_q   <= (state_nxt == OWN0);
      gnt1_q   <= (state_nxt == OWN1);
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign sel       = sel_q;
  assign data_out  = sel_q ? data1 : data0;
  assign valid_out = gnt0_q | gnt1_q;
  assign busy      = valid_out;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter. Three instances share the same stimulus:
// u_h8 (MAX_HOLD=8), u_h0 (preemption disabled) and u_h4 (MAX_HOLD=4).
// Inputs change 1 time unit after the rising edge, outputs are sampled there.

module tb_mux_arbiter;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1;
  logic [W-1:0] data0, data1;

  logic         g0_8, g1_8, sel_8, v_8, b_8;
  logic [W-1:0] do_8;
  logic         g0_0, g1_0, sel_0, v_0, b_0;
  logic [W-1:0] do_0;
  logic         g0_4, g1_4, sel_4, v_4, b_4;
  logic [W-1:0] do_4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_arbiter #(.WIDTH(W), .MAX_HOLD(8)) u_h8 (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .gnt0(g0_8), .gnt1(g1_8), .sel(sel_8),
    .data_out(do_8), .valid_out(v_8), .busy(b_8));

  mux_arbiter #(.WIDTH(W), .MAX_HOLD(0)) u_h0 (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .gnt0(g0_0), .gnt1(g1_0), .sel(sel_0),
    .data_out(do_0), .valid_out(v_0), .busy(b_0));

  mux_arbiter #(.WIDTH(W), .MAX_HOLD(4)) u_h4 (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .gnt0(g0_4), .gnt1(g1_4), .sel(sel_4),
    .data_out(do_4), .valid_out(v_4), .busy(b_4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Structural invariants on every instance, checked between edges.
  always @(negedge clk) begin
    if (!reset) begin
      check("h8_excl", {31'd0, g0_8 & g1_8}, 32'd0);
      check("h0_excl", {31'd0, g0_0 & g1_0}, 32'd0);
      check("h4_excl", {31'd0, g0_4 & g1_4}, 32'd0);
      check("h8_busy", {31'd0, b_8}, {31'd0, v_8});
      if (v_8) check("h8_sel_gnt", {31'd0, sel_8}, {31'd0, g1_8});
      if (v_0) check("h0_sel_gnt", {31'd0, sel_0}, {31'd0, g1_0});
      if (v_4) check("h4_sel_gnt", {31'd0, sel_4}, {31'd0, g1_4});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    #1;
    check("rst_gnt0", {31'd0, g0_8}, 32'd0);
    check("rst_gnt1", {31'd0, g1_8}, 32'd0);
    check("rst_sel",  {31'd0, sel_8}, 32'd0);
    check("rst_valid", {31'd0, v_8}, 32'd0);
    step(); step();
    reset = 1'b0;

    // Reset during a grant to requester 1 clears outputs without a clock.
    req1 = 1'b1; data1 = 5'h0A;
    step();
    check("t1_gnt1", {31'd0, g1_8}, 32'd1);
    check("t1_sel1", {31'd0, sel_8}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t1_async_gnt0",  {31'd0, g0_8}, 32'd0);
    check("t1_async_gnt1",  {31'd0, g1_8}, 32'd0);
    check("t1_async_sel",   {31'd0, sel_8}, 32'd0);
    check("t1_async_valid", {31'd0, v_8}, 32'd0);
    check("t1_async_busy",  {31'd0, b_8}, 32'd0);
    req0 = 1'b1; req1 = 1'b1;
    #1;
    reset = 1'b0;
    step();
    check("t1_first_gnt0", {31'd0, g0_8}, 32'd1);
    check("t1_first_gnt1", {31'd0, g1_8}, 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    step();
    check("t1_idle", {31'd0, v_8}, 32'd0);

    // Single requester for three cycles.
    data0 = 5'h15; data1 = 5'h0A; req0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_gnt0",  {31'd0, g0_8}, 32'd1);
      check("t2_sel",   {31'd0, sel_8}, 32'd0);
      check("t2_data",  {27'd0, do_8}, 32'h15);
      check("t2_valid", {31'd0, v_8}, 32'd1);
    end
    req0 = 1'b0;
    step();
    check("t2_drop_gnt0",  {31'd0, g0_8}, 32'd0);
    check("t2_drop_valid", {31'd0, v_8}, 32'd0);
    check("t2_idle_sel",   {31'd0, sel_8}, 32'd0);

    // Tie after reset, handover without a bubble, round robin.
    reset = 1'b1; #1; reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    step();
    check("t3_tie_gnt0", {31'd0, g0_8}, 32'd1);
    req0 = 1'b0;
    step();
    check("t3_hand_gnt1", {31'd0, g1_8}, 32'd1);
    check("t3_hand_gnt0", {31'd0, g0_8}, 32'd0);
    check("t3_hand_sel",  {31'd0, sel_8}, 32'd1);
    check("t3_hand_data", {27'd0, do_8}, 32'h0A);
    data1 = 5'h1F;
    #1;
    check("t3_comb_data", {27'd0, do_8}, 32'h1F);
    req1 = 1'b0;
    step();
    check("t3_idle_valid", {31'd0, v_8}, 32'd0);
    check("t3_idle_sel",   {31'd0, sel_8}, 32'd1);
    req0 = 1'b1; req1 = 1'b1;
    step();
    check("t3_rr_gnt0", {31'd0, g0_8}, 32'd1);
    check("t3_rr_sel",  {31'd0, sel_8}, 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    step();
    check("t3_end_idle", {31'd0, v_8}, 32'd0);

    // Hold limit of 8 with req1 arriving in the third grant cycle.
    req0 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("t4_hold_gnt0", {31'd0, g0_8}, 32'd1);
      check("t4_hold_gnt1", {31'd0, g1_8}, 32'd0);
      if (i == 3) req1 = 1'b1;
    end
    step();
    check("t4_preempt_gnt1", {31'd0, g1_8}, 32'd1);
    check("t4_preempt_gnt0", {31'd0, g0_8}, 32'd0);
    check("t4_preempt_sel",  {31'd0, sel_8}, 32'd1);
    req0 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      check("t4_nocontend_gnt1", {31'd0, g1_8}, 32'd1);
    end
    req1 = 1'b0;
    step();
    check("t4_end_idle", {31'd0, v_8}, 32'd0);

    // Preemption disabled (u_h0) and 4/4 alternation (u_h4), same stimulus.
    reset = 1'b1; #1; reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      step();
      check("t5_h0_gnt0", {31'd0, g0_0}, 32'd1);
      check("t5_h0_gnt1", {31'd0, g1_0}, 32'd0);
      if (k <= 40) begin
        check("t6_h4_gnt0", {31'd0, g0_4}, (((k - 1) / 4) % 2 == 0) ? 32'd1 : 32'd0);
        check("t6_h4_gnt1", {31'd0, g1_4}, (((k - 1) / 4) % 2 == 1) ? 32'd1 : 32'd0);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    check("t5_end_idle", {31'd0, v_0}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
